// File: rtl/lsu_rmw_pkg.sv
// Shared definitions for the load/store unit.
// funct3 codes, FSM state type and the alignment/legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    IDLE,
    MERGE
  } lsu_state_t;

  function automatic logic is_misaligned(
    input logic [2:0] funct3,
    input logic [1:0] addr
  );
    logic m;
    m = 1'b0;
    case (funct3)
      F3_H, F3_HU: m = addr[0];
      F3_W:        m = |addr;
      default:     m = 1'b0;
    endcase
    return m;
  endfunction

  // Stores have no unsigned forms, so only B/H/W are legal for them.
  function automatic logic is_legal(
    input logic       we,
    input logic [2:0] funct3
  );
    logic l;
    l = 1'b0;
    case (funct3)
      F3_B, F3_H, F3_W: l = 1'b1;
      F3_BU, F3_HU:     l = !we;
      default:          l = 1'b0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/lsu_rmw_if.sv
// Core-side request/response bundle of the load/store unit.
// master = core, slave = lsu.
interface lsu_rmw_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  modport master (
    output req_valid, req_we, req_funct3,
    output req_addr, req_wdata,
    input  req_ready,
    input  resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3,
    input  req_addr, req_wdata,
    output req_ready,
    output resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/lsu_rmw_align.sv
// Lane extraction for loads and lane merging for sub-word stores.
// Purely combinational.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] load_data,
  output logic [31:0] merge_word
);

  function automatic logic [31:0] load_extract(
    input logic [31:0] w,
    input logic [1:0]  a,
    input logic [2:0]  f3
  );
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{a, 3'b000} +: 8];
    h = a[1] ? w[31:16] : w[15:0];
    case (f3)
      F3_B:    r = {{24{b[7]}}, b};
      F3_BU:   r = {24'h0, b};
      F3_H:    r = {{16{h[15]}}, h};
      F3_HU:   r = {16'h0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] store_merge(
    input logic [31:0] old,
    input logic [31:0] wd,
    input logic [1:0]  a,
    input logic [2:0]  f3
  );
    logic [31:0] m;
    m = old;
    case (f3)
      F3_B: m[{a, 3'b000} +: 8] = wd[7:0];
      F3_H: begin
        if (a[1]) m[31:16] = wd[15:0];
        else      m[15:0]  = wd[15:0];
      end
      default: m = wd;
    endcase
    return m;
  endfunction

  assign load_data  = load_extract(word, off, funct3);
  assign merge_word = store_merge(word, wdata, off, funct3);

endmodule

// File: rtl/lsu_rmw.sv
// Load/store unit in front of a word-only dmem.
// Sub-word stores take a read cycle plus a MERGE write cycle.
module lsu_rmw
  import lsu_pkg::*;
#(
  parameter int DMEM_ADDR_WIDTH = 10
) (
  input  logic                       clk,
  input  logic                       reset_n,
  lsu_rmw_if.slave                   bus,
  output logic [DMEM_ADDR_WIDTH-1:0] dmem_addr,
  output logic [31:0]                dmem_din,
  output logic                       dmem_read,
  output logic                       dmem_write,
  input  logic [31:0]                dmem_dout
);

  lsu_state_t                 state;
  logic [DMEM_ADDR_WIDTH-1:0] addr_q;
  logic [31:0]                merge_q;

  logic                       accept;
  logic                       err;
  logic                       ok;
  logic                       is_word;
  logic                       rmw;
  logic [DMEM_ADDR_WIDTH-1:0] word_idx;
  logic [31:0]                load_data;
  logic [31:0]                merge_word;

  // Upper address bits wrap into dmem.
  logic unused_addr_hi;
  assign unused_addr_hi =
    ^bus.req_addr[31:DMEM_ADDR_WIDTH+2];

  assign bus.req_ready = (state == IDLE);

  assign accept   = bus.req_valid & (state == IDLE);
  assign err      = !is_legal(bus.req_we, bus.req_funct3)
                  | is_misaligned(bus.req_funct3,
                                  bus.req_addr[1:0]);
  assign ok       = accept & !err;
  assign is_word  = (bus.req_funct3 == F3_W);
  assign rmw      = ok & bus.req_we & !is_word;
  assign word_idx = bus.req_addr[DMEM_ADDR_WIDTH+1:2];

  lsu_align u_align (
    .word       (dmem_dout),
    .wdata      (bus.req_wdata),
    .off        (bus.req_addr[1:0]),
    .funct3     (bus.req_funct3),
    .load_data  (load_data),
    .merge_word (merge_word)
  );

  always_comb begin
    dmem_read  = ok & (!bus.req_we | !is_word);
    dmem_write = ok & bus.req_we & is_word;
    dmem_addr  = word_idx;
    dmem_din   = bus.req_wdata;
    if (state == MERGE) begin
      dmem_read  = 1'b0;
      dmem_write = 1'b1;
      dmem_addr  = addr_q;
      dmem_din   = merge_q;
    end
  end

  // resp_valid for a sub-word store lands in the MERGE cycle itself.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      addr_q         <= '0;
      merge_q        <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_err   <= 1'b0;
    end else begin
      bus.resp_valid <= accept;
      unique case (state)
        IDLE: begin
          if (accept) begin
            bus.resp_err   <= err;
            bus.resp_rdata <= (ok & !bus.req_we)
                            ? load_data : 32'h0;
          end
          if (rmw) begin
            state   <= MERGE;
            addr_q  <= word_idx;
            merge_q <= merge_word;
          end
        end
        MERGE: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_rmw.sv
// Self-checking bench for lsu_rmw.
// Directed cases, then random ops against a word-array model.
module tb_lsu_rmw;

  logic        clk;
  logic        reset_n;
  logic [9:0]  dmem_addr;
  logic [31:0] dmem_din;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_dout;

  logic [31:0] mem [1024];
  logic        pre_we;
  logic [9:0]  pre_idx;
  logic [31:0] pre_data;

  logic [31:0] ref_mem [16];
  int          nchk;
  int          nfail;
  logic [31:0] got;

  lsu_rmw_if bus ();

  lsu_rmw #(.DMEM_ADDR_WIDTH(10)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .bus        (bus),
    .dmem_addr  (dmem_addr),
    .dmem_din   (dmem_din),
    .dmem_read  (dmem_read),
    .dmem_write (dmem_write),
    .dmem_dout  (dmem_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign dmem_dout = mem[dmem_addr];

  always @(posedge clk) begin
    if (dmem_write)  mem[dmem_addr] <= dmem_din;
    else if (pre_we) mem[pre_idx]   <= pre_data;
  end

  task automatic check(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    nchk++;
    if (obs !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit ref_err(
    input bit         we,
    input logic [2:0] f3,
    input logic [1:0] a
  );
    bit legal;
    bit mis;
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    mis = ((f3 == 3'd1 || f3 == 3'd5) && a[0])
       || (f3 == 3'd2 && a != 2'd0);
    return !legal || mis;
  endfunction

  function automatic logic [31:0] ref_load(
    input logic [31:0] w,
    input logic [1:0]  a,
    input logic [2:0]  f3
  );
    logic [31:0] b;
    logic [31:0] h;
    b = (w >> (8 * a)) & 32'hFF;
    h = (w >> (16 * a[1])) & 32'hFFFF;
    if (f3 == 3'd0) return (b >= 32'h80) ? b - 32'h100 : b;
    if (f3 == 3'd4) return b;
    if (f3 == 3'd1) return (h >= 32'h8000) ? h - 32'h10000 : h;
    if (f3 == 3'd5) return h;
    return w;
  endfunction

  function automatic logic [31:0] ref_store(
    input logic [31:0] w,
    input logic [31:0] wd,
    input logic [1:0]  a,
    input logic [2:0]  f3
  );
    int sh;
    if (f3 == 3'd0) begin
      sh = 8 * a;
      return (w & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
    end
    if (f3 == 3'd1) begin
      sh = 16 * a[1];
      return (w & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  task automatic op(
    input  bit          we,
    input  logic [2:0]  f3,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic [31:0] rdata
  );
    int          cyc;
    bit          e;
    bit          sub;
    logic [3:0]  idx;
    logic [31:0] expw;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    #1;
    cyc = 0;
    while (!bus.req_ready && cyc < 20) begin
      @(negedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 20) check("ready_timeout", 32'(cyc), 32'd0);
    e   = ref_err(we, f3, a[1:0]);
    sub = !e && we && (f3 != 3'd2);
    idx = a[5:2];
    check("dmem_read", 32'(dmem_read), 32'(!e && (!we || sub)));
    check("dmem_write", 32'(dmem_write),
          32'(!e && we && f3 == 3'd2));
    if (!e) check("dmem_addr", 32'(dmem_addr), 32'(a[11:2]));
    if (!e && we && f3 == 3'd2)
      check("sw_din", dmem_din, wd);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    if (sub) begin
      expw = ref_store(ref_mem[idx], wd, a[1:0], f3);
      check("merge_ready", 32'(bus.req_ready), 32'd0);
      check("merge_write", 32'(dmem_write), 32'd1);
      check("merge_addr", 32'(dmem_addr), 32'(a[11:2]));
      check("merge_din", dmem_din, expw);
      check("merge_valid", 32'(bus.resp_valid), 32'd1);
      check("merge_err", 32'(bus.resp_err), 32'd0);
      rdata = bus.resp_rdata;
      check("merge_rdata", rdata, 32'h0);
      ref_mem[idx] = expw;
      @(posedge clk);
      #1;
      check("post_merge_valid", 32'(bus.resp_valid), 32'd0);
      check("post_merge_write", 32'(dmem_write), 32'd0);
    end else begin
      check("resp_valid", 32'(bus.resp_valid), 32'd1);
      check("resp_err", 32'(bus.resp_err), 32'(e));
      rdata = bus.resp_rdata;
      if (e || we) check("resp_rdata", rdata, 32'h0);
      else check("load_data", rdata,
                 ref_load(ref_mem[idx], a[1:0], f3));
      if (!e && we) ref_mem[idx] = wd;
    end
  endtask

  initial begin
    nchk           = 0;
    nfail          = 0;
    reset_n        = 1'b0;
    pre_we         = 1'b0;
    pre_idx        = '0;
    pre_data       = '0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pre_we   = 1'b1;
      pre_idx  = 10'(i);
      pre_data = (i == 0) ? 32'h8899_AABB : $urandom;
      ref_mem[i] = pre_data;
    end
    @(negedge clk);
    pre_we = 1'b0;
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd1);
    check("rst_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_rdata", bus.resp_rdata, 32'h0);
    check("rst_err", 32'(bus.resp_err), 32'd0);
    check("rst_write", 32'(dmem_write), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    op(0, 3'd0, 32'h3, 0, got); check("lb3", got, 32'hFFFF_FF88);
    op(0, 3'd4, 32'h3, 0, got); check("lbu3", got, 32'h0000_0088);
    op(0, 3'd1, 32'h2, 0, got); check("lh2", got, 32'hFFFF_8899);
    op(0, 3'd5, 32'h0, 0, got); check("lhu0", got, 32'h0000_AABB);
    op(0, 3'd2, 32'h0, 0, got); check("lw0", got, 32'h8899_AABB);
    op(1, 3'd0, 32'h1, 32'h5A, got);
    op(0, 3'd2, 32'h0, 0, got); check("lw_sb", got, 32'h8899_5ABB);
    op(1, 3'd2, 32'h0, 32'h8899_AABB, got);
    op(1, 3'd1, 32'h2, 32'h1234, got);
    op(1, 3'd2, 32'h4, 32'hDEAD_BEEF, got);
    op(0, 3'd2, 32'h0, 0, got); check("lw_sh", got, 32'h1234_AABB);
    op(0, 3'd2, 32'h4, 0, got); check("lw_sw", got, 32'hDEAD_BEEF);
    op(0, 3'd2, 32'h6, 0, got);
    op(1, 3'd1, 32'h1, 32'hFFFF, got);
    op(0, 3'd3, 32'h0, 0, got);
    op(0, 3'd2, 32'h0, 0, got); check("lw_err", got, 32'h1234_AABB);
    op(0, 3'd2, 32'hFFFF_F004, 0, got);
    check("lw_wrap", got, 32'hDEAD_BEEF);

    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = 3'd0;
    bus.req_addr   = 32'h0;
    bus.req_wdata  = 32'hFF;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    check("rst_m_write", 32'(dmem_write), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_m_drop", 32'(dmem_write), 32'd0);
    check("rst_m_valid", 32'(bus.resp_valid), 32'd0);
    check("rst_m_ready", 32'(bus.req_ready), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("rst_m_novalid", 32'(bus.resp_valid), 32'd0);
    @(negedge clk);
    op(0, 3'd2, 32'h0, 0, got); check("lw_rst", got, 32'h1234_AABB);

    for (int n = 0; n < 300; n++) begin
      bit          we;
      logic [2:0]  f3;
      logic [31:0] a;
      logic [2:0]  legal [5];
      legal[0] = 3'd0; legal[1] = 3'd1; legal[2] = 3'd2;
      legal[3] = 3'd4; legal[4] = 3'd5;
      we = 1'($urandom);
      if ($urandom_range(3) != 0) f3 = legal[$urandom_range(4)];
      else                        f3 = 3'($urandom);
      a = $urandom;
      a[11:6] = 6'd0;
      if ($urandom_range(3) == 0) begin
        @(posedge clk);
        #1;
      end
      op(we, f3, a, $urandom, got);
    end

    for (int i = 0; i < 16; i++) begin
      op(0, 3'd2, 32'(i * 4), 0, got);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nfail);
    $finish;
  end

endmodule
